reg_file_sb: RTL

- Parametrised successor of the two-read/one-write integer register file.
- Provides NUM_RD combinational read ports, one writeback port with write-through bypass, a hardwired-zero register 0, and a per-register busy scoreboard.
- The scoreboard is set when ID issues a producer and cleared on WB writeback.
- Sits between the ID stage, which reads operands and busy bits and issues destinations, and the WB stage, which writes results. ID uses the busy bits to stall on RAW hazards.

---
 rtl/reg_file_sb.sv | 91 +++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Multi-ported integer register file with write-through bypass and a per-register
// busy scoreboard (set on issue, cleared on writeback, wiped by flush).
module reg_file_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wb_we,
    input  logic [ADDR_WIDTH-1:0]          wb_waddr,
    input  logic [DATA_WIDTH-1:0]          wb_wdata,
    input  logic                           iss_valid,
    input  logic [ADDR_WIDTH-1:0]          iss_waddr,
    input  logic                           flush,
    output logic [(2**ADDR_WIDTH)-1:0]     busy_vec
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam bit          HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0]               regs [DEPTH];
    logic [DEPTH-1:0]                    busy;
    logic [DEPTH-1:0]                    busy_next;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]   data;
    logic                                wb_ok;

    assign addr     = rd_addr;
    assign rd_data  = data;
    assign busy_vec = busy;
    assign wb_ok    = wb_we && !(HAS_ZERO && wb_waddr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_ok) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    // Later assignments take priority: flush over issue, issue over writeback clear.
    always_comb begin
        busy_next = busy;
        if (wb_we) begin
            busy_next[wb_waddr] = 1'b0;
        end
        if (iss_valid) begin
            busy_next[iss_waddr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        if (HAS_ZERO) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // A register being written this cycle reads the bypassed data and is not busy.
    always_comb begin
        data    = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (HAS_ZERO && addr[i] == '0) begin
                data[i]    = '0;
                rd_busy[i] = 1'b0;
            end else if (wb_we && wb_waddr == addr[i]) begin
                data[i]    = wb_wdata;
                rd_busy[i] = 1'b0;
            end else begin
                data[i]    = regs[addr[i]];
                rd_busy[i] = busy[addr[i]];
            end
        end
    end

endmodule
